// File: rtl/otf_sd_converter_if.sv
// Handshake bundle between the online adder output and the
// on-the-fly signed-digit to two's-complement converter.
interface otf_sd_converter_if #(
    parameter int N_DIGITS = 8
);
    logic                start;
    logic [1:0]          digit_in;
    logic                digit_vld;
    logic                busy;
    logic [N_DIGITS:0]   result;
    logic                result_vld;
    logic                digit_err;

    modport master (
        output start, digit_in, digit_vld,
        input  busy, result, result_vld, digit_err
    );

    modport slave (
        input  start, digit_in, digit_vld,
        output busy, result, result_vld, digit_err
    );
endinterface

// File: rtl/otf_sd_converter.sv
// On-the-fly conversion of an MSD-first radix-2 signed-digit stream
// into a two's-complement word using Q/QM shift-and-append registers.
module otf_sd_converter #(
    parameter int N_DIGITS = 8,
    parameter int DELTA    = 2
) (
    input  logic              clk,
    input  logic              asyn_reset,
    otf_sd_converter_if.slave bus
);
    localparam int W    = N_DIGITS + 1;
    localparam int MAXC = (N_DIGITS > DELTA) ? N_DIGITS : DELTA;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SKIP_LAST = CW'((DELTA > 0) ? DELTA - 1 : 0);
    localparam logic [CW-1:0] CONV_LAST = CW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_CONV = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_qm;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic          r_err_sticky;
    logic          r_digit_err;
    logic          r_result_vld;

    logic          w_load;
    logic          w_skip;
    logic          w_conv;
    logic          w_busy;
    logic          w_skip_done;
    logic          w_conv_done;
    logic          w_inv;
    logic [W-1:0]  w_q_nxt;
    logic [W-1:0]  w_qm_nxt;

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (DELTA > 0) ? S_SKIP : S_CONV;
                end
            end
            S_SKIP: begin
                if (w_skip_done) begin
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        w_skip = 1'b0;
        w_conv = 1'b0;
        unique case (r_state)
            S_IDLE: w_load = bus.start;
            S_SKIP: begin
                w_busy = 1'b1;
                w_skip = bus.digit_vld;
            end
            S_CONV: begin
                w_busy = 1'b1;
                w_conv = bus.digit_vld;
            end
            default: ;
        endcase
    end

    assign w_skip_done = w_skip && (r_cnt == SKIP_LAST);
    assign w_conv_done = w_conv && (r_cnt == CONV_LAST);

    // Invalid digit 2'b11 falls through to the zero-digit update.
    always_comb begin
        w_q_nxt  = {r_q[W-2:0], 1'b0};
        w_qm_nxt = {r_qm[W-2:0], 1'b1};
        w_inv    = 1'b0;
        unique case (bus.digit_in)
            2'b10: begin
                w_q_nxt  = {r_q[W-2:0], 1'b1};
                w_qm_nxt = {r_q[W-2:0], 1'b0};
            end
            2'b01: begin
                w_q_nxt  = {r_qm[W-2:0], 1'b1};
                w_qm_nxt = {r_qm[W-2:0], 1'b0};
            end
            2'b11: w_inv = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_q          <= '0;
            r_qm         <= '1;
            r_cnt        <= '0;
            r_err_sticky <= 1'b0;
            r_result     <= '0;
            r_digit_err  <= 1'b0;
            r_result_vld <= 1'b0;
        end else begin
            r_result_vld <= w_conv_done;
            if (w_load) begin
                r_q          <= '0;
                r_qm         <= '1;
                r_cnt        <= '0;
                r_err_sticky <= 1'b0;
            end
            if (w_skip) begin
                r_cnt <= w_skip_done ? '0 : r_cnt + CW'(1);
            end
            if (w_conv) begin
                r_q          <= w_q_nxt;
                r_qm         <= w_qm_nxt;
                r_err_sticky <= r_err_sticky | w_inv;
                r_cnt        <= w_conv_done ? '0 : r_cnt + CW'(1);
            end
            if (w_conv_done) begin
                r_result    <= w_q_nxt;
                r_digit_err <= r_err_sticky | w_inv;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.result     = r_result;
    assign bus.result_vld = r_result_vld;
    assign bus.digit_err  = r_digit_err;
endmodule

// File: tb/tb_otf_sd_converter.sv
// Directed bench for otf_sd_converter with an arithmetic reference
// model (weighted digit sum) and a per-cycle output checker.
module tb_otf_sd_converter;
    localparam int N = 4;
    localparam int D = 2;

    typedef logic [1:0] dig_t;
    typedef dig_t dv_t [N];

    logic clk = 1'b0;
    logic rst;
    logic rst_q;
    always #5 clk = ~clk;

    otf_sd_converter_if #(.N_DIGITS(N)) bus ();

    otf_sd_converter #(
        .N_DIGITS(N),
        .DELTA   (D)
    ) dut (
        .clk       (clk),
        .asyn_reset(rst),
        .bus       (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [N+1:0] expq[$];
    logic [N:0]   exp_res = '0;
    logic         exp_err = 1'b0;
    bit           armed   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dval(input dig_t d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    // Value of the digit string scaled by 2^(N-1), wrapped to N+1 bits.
    function automatic logic [N:0] model_res(input dv_t d);
        int v = 0;
        for (int i = 0; i < N; i++) v = 2 * v + dval(d[i]);
        return (N+1)'(v);
    endfunction

    function automatic logic model_err(input dv_t d);
        logic e = 1'b0;
        for (int i = 0; i < N; i++) if (d[i] == 2'b11) e = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (armed) begin
            if (rst_q) begin
                exp_res = '0;
                exp_err = 1'b0;
                chk("rst_no_vld", {31'd0, bus.result_vld}, 0);
            end else if (bus.result_vld) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vld: got 1 expected 0");
                end else begin
                    {exp_err, exp_res} = expq.pop_front();
                end
            end
            chk("cyc_result", {27'd0, bus.result}, {27'd0, exp_res});
            chk("cyc_err", {31'd0, bus.digit_err}, {31'd0, exp_err});
        end
    end

    task automatic run_conv(input dv_t d, input dig_t s0, input dig_t s1,
                            input int gap, input int mid_start,
                            output int lat);
        dig_t seq [N+D];
        seq[0] = s0;
        seq[1] = s1;
        for (int i = 0; i < N; i++) seq[D+i] = d[i];
        expq.push_back({model_err(d), model_res(d)});
        bus.start     = 1'b1;
        bus.digit_vld = 1'b1;
        bus.digit_in  = 2'b10;
        tick();
        lat = 1;
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 1);
        for (int k = 0; k < N + D; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.digit_vld = 1'b0;
                    bus.digit_in  = 2'($urandom_range(3, 0));
                    tick();
                    lat++;
                end
            end
            bus.digit_vld = 1'b1;
            bus.digit_in  = seq[k];
            bus.start     = (k == mid_start);
            tick();
            lat++;
            bus.start = 1'b0;
        end
        bus.digit_vld = 1'b0;
        bus.digit_in  = 2'b00;
        chk("vld_after_last", {31'd0, bus.result_vld}, 1);
        chk("busy_in_pulse", {31'd0, bus.busy}, 0);
    endtask

    initial begin
        dv_t dv;
        int  lat;
        bus.start     = 1'b0;
        bus.digit_vld = 1'b0;
        bus.digit_in  = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_result", {27'd0, bus.result}, 0);
        chk("reset_vld", {31'd0, bus.result_vld}, 0);
        chk("reset_err", {31'd0, bus.digit_err}, 0);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        rst = 1'b0;
        tick();
        armed = 1'b1;

        bus.digit_vld = 1'b1;
        bus.digit_in  = 2'b10;
        repeat (3) tick();
        chk("idle_busy", {31'd0, bus.busy}, 0);

        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        run_conv(dv, 2'b00, 2'b00, 0, -1, lat);
        chk("t1_latency", lat, 7);
        chk("t1_result", {27'd0, bus.result}, 32'h07);
        chk("t1_err", {31'd0, bus.digit_err}, 0);

        dv = '{2'b01, 2'b01, 2'b01, 2'b01};
        run_conv(dv, 2'b00, 2'b00, 0, -1, lat);
        chk("t2_result", {27'd0, bus.result}, 32'h11);
        dv = '{2'b00, 2'b00, 2'b00, 2'b00};
        run_conv(dv, 2'b00, 2'b00, 0, -1, lat);
        chk("t2b_result", {27'd0, bus.result}, 32'h00);

        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        run_conv(dv, 2'b01, 2'b10, 3, -1, lat);
        chk("t3_result", {27'd0, bus.result}, 32'h07);
        chk("t3_latency", lat, 22);

        dv = '{2'b10, 2'b11, 2'b00, 2'b00};
        run_conv(dv, 2'b00, 2'b00, 0, -1, lat);
        chk("t4_result", {27'd0, bus.result}, 32'h08);
        chk("t4_err", {31'd0, bus.digit_err}, 1);
        repeat (2) tick();
        dv = '{2'b01, 2'b10, 2'b00, 2'b00};
        run_conv(dv, 2'b11, 2'b11, 0, -1, lat);
        chk("t4b_result", {27'd0, bus.result}, 32'h1c);
        chk("t4b_err", {31'd0, bus.digit_err}, 0);

        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        run_conv(dv, 2'b00, 2'b00, 0, 3, lat);
        chk("t5_result", {27'd0, bus.result}, 32'h07);
        chk("t5_latency", lat, 7);

        bus.start     = 1'b1;
        bus.digit_vld = 1'b1;
        bus.digit_in  = 2'b00;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.digit_in = 2'b10;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.digit_vld = 1'b0;
        chk("abort_result", {27'd0, bus.result}, 0);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_vld", {31'd0, bus.result_vld}, 0);
        repeat (3) tick();

        dv = '{2'b10, 2'b10, 2'b01, 2'b00};
        run_conv(dv, 2'b00, 2'b00, 0, -1, lat);
        chk("t6_result", {27'd0, bus.result}, 32'h0a);
        chk("t6_latency", lat, 7);

        repeat (4) tick();
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
